// File: rtl/spi_master_n.sv
// Multi-slave SPI master: configurable word width, per-transfer CPOL/CPHA/bit order,
// and chip-select hold so bursts to the same slave skip the setup half-period.
module spi_master_n #(
   parameter int DW     = 8,
   parameter int NSS    = 4,
   parameter int DVSR_W = 16,
   parameter int SSW    = (NSS > 1) ? $clog2(NSS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DW-1:0]     din,
   input  logic [DVSR_W-1:0] dvsr,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [SSW-1:0]    ss_sel,
   input  logic              hold,
   input  logic              miso,
   output logic [DW-1:0]     dout,
   output logic              ready,
   output logic              done,
   output logic              sclk,
   output logic              mosi,
   output logic [NSS-1:0]    ss_n
);
   localparam int BW = $clog2(DW);

   typedef enum logic [2:0] {IDLE, SETUP, HALF_A, HALF_B, DONE} state_t;

   state_t            state, state_nx;
   logic [DVSR_W-1:0] cnt, cnt_nx, dvsr_q, dvsr_nx;
   logic [BW-1:0]     bit_cnt, bit_cnt_nx;
   logic              cpol_q, cpol_nx, cpha_q, cpha_nx, lsb_q, lsb_nx, hold_q, hold_nx;
   logic [DW-1:0]     tx_sr, tx_sr_nx, rx_sr, rx_sr_nx, dout_nx;
   logic              ready_nx, done_nx, sclk_nx, mosi_nx;
   logic [NSS-1:0]    ss_n_nx;
   logic              skip;

   // Active-low one-cold decode; indices at or above NSS select nobody.
   function automatic logic [NSS-1:0] sel_mask(input logic [SSW-1:0] sel);
      logic [NSS-1:0] m;
      m = '1;
      for (int i = 0; i < NSS; i++)
         if (sel == SSW'(i)) m[i] = 1'b0;
      return m;
   endfunction

   // Target select still held low from a previous burst word.
   assign skip = |(~ss_n & ~sel_mask(ss_sel));

   always_comb begin
      // NOTE: every next-value signal is defaulted first so no branch can infer a latch.
      state_nx   = state;
      cnt_nx     = cnt;
      bit_cnt_nx = bit_cnt;
      dvsr_nx    = dvsr_q;
      cpol_nx    = cpol_q;
      cpha_nx    = cpha_q;
      lsb_nx     = lsb_q;
      hold_nx    = hold_q;
      tx_sr_nx   = tx_sr;
      rx_sr_nx   = rx_sr;
      dout_nx    = dout;
      mosi_nx    = mosi;
      ss_n_nx    = ss_n;
      done_nx    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               dvsr_nx    = dvsr;
               cpol_nx    = cpol;
               cpha_nx    = cpha;
               lsb_nx     = lsb_first;
               hold_nx    = hold;
               tx_sr_nx   = din;
               rx_sr_nx   = '0;
               cnt_nx     = '0;
               bit_cnt_nx = '0;
               ss_n_nx    = sel_mask(ss_sel);
               mosi_nx    = lsb_first ? din[0] : din[DW-1];
               state_nx   = skip ? HALF_A : SETUP;
            end
         end
         SETUP: begin
            if (cnt == dvsr_q) begin
               cnt_nx   = '0;
               state_nx = HALF_A;
            end else begin
               cnt_nx = cnt + DVSR_W'(1);
            end
         end
         HALF_A: begin
            if (cnt == dvsr_q) begin
               cnt_nx   = '0;
               rx_sr_nx = lsb_q ? {miso, rx_sr[DW-1:1]} : {rx_sr[DW-2:0], miso};
               state_nx = HALF_B;
            end else begin
               cnt_nx = cnt + DVSR_W'(1);
            end
         end
         HALF_B: begin
            if (cnt == dvsr_q) begin
               cnt_nx = '0;
               if (bit_cnt == BW'(DW - 1)) begin
                  state_nx = DONE;
                  done_nx  = 1'b1;
                  dout_nx  = rx_sr;
                  if (!hold_q) ss_n_nx = '1;
               end else begin
                  bit_cnt_nx = bit_cnt + BW'(1);
                  tx_sr_nx   = lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
                  mosi_nx    = lsb_q ? tx_sr[1] : tx_sr[DW-2];
                  state_nx   = HALF_A;
               end
            end else begin
               cnt_nx = cnt + DVSR_W'(1);
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // Pin levels are decoded from the state being entered so they leave a flop.
      ready_nx = (state_nx == IDLE);
      if (state_nx == IDLE) mosi_nx = 1'b0;
      case (state_nx)
         IDLE:    sclk_nx = cpol;
         HALF_A:  sclk_nx = cpol_nx ^ cpha_nx;
         HALF_B:  sclk_nx = ~(cpol_nx ^ cpha_nx);
         default: sclk_nx = cpol_nx;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         dvsr_q  <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
         hold_q  <= 1'b0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         dout    <= '0;
         ready   <= 1'b1;
         done    <= 1'b0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         ss_n    <= '1;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_cnt <= bit_cnt_nx;
         dvsr_q  <= dvsr_nx;
         cpol_q  <= cpol_nx;
         cpha_q  <= cpha_nx;
         lsb_q   <= lsb_nx;
         hold_q  <= hold_nx;
         tx_sr   <= tx_sr_nx;
         rx_sr   <= rx_sr_nx;
         dout    <= dout_nx;
         ready   <= ready_nx;
         done    <= done_nx;
         sclk    <= sclk_nx;
         mosi    <= mosi_nx;
         ss_n    <= ss_n_nx;
      end
   end
endmodule
